// File: rtl/matrix_mult_pkg.sv
// matrix_mult_pkg: default dimensions and full-width sum helper for matrix_mult
package matrix_mult_pkg;
  localparam int N_DEF = 3;
  localparam int DATA_W_DEF = 8;
  localparam int OUT_W_DEF = 16;
  function automatic int sum_w(input int data_w, input int n);
    return 2 * data_w + $clog2(n);
  endfunction
endpackage

// File: rtl/matrix_mult_dot.sv
// matrix_mult_dot: pipelined dot-product lane, wraps or clamps (MATMUL_SAT_EN) to OUT_W
module matrix_mult_dot
  import matrix_mult_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] i_a [0:N-1],
  input  logic [DATA_W-1:0] i_b [0:N-1],
  output logic [OUT_W-1:0]  o_dot
);
  localparam int FW = sum_w(DATA_W, N);
  // Never narrower than OUT_W so the low slice and overflow test stay legal
  localparam int SW = FW > OUT_W ? FW : OUT_W;
  logic [2*DATA_W-1:0] r_prod [0:N-1];
  logic [SW-1:0]       w_sum;
  logic [OUT_W-1:0]    w_res;
  logic [OUT_W-1:0]    r_dot;
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < N; k++) w_sum = w_sum + SW'(r_prod[k]);
`ifdef MATMUL_SAT_EN
    w_res = |(w_sum >> OUT_W) ? '1 : w_sum[OUT_W-1:0];
`else
    w_res = w_sum[OUT_W-1:0];
`endif
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_prod <= '{default: '0};
      r_dot <= '0;
    end else if (enable) begin
      for (int k = 0; k < N; k++) r_prod[k] <= (2*DATA_W)'(i_a[k]) * (2*DATA_W)'(i_b[k]);
      r_dot <= w_res;
    end
  assign o_dot = r_dot;
endmodule

// File: rtl/matrix_mult.sv
// matrix_mult: two-stage pipelined NxN unsigned matrix multiplier, optional MATMUL_SAT_EN saturation
module matrix_mult
  import matrix_mult_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] a      [0:N-1][0:N-1],
  input  logic [DATA_W-1:0] b      [0:N-1][0:N-1],
  output logic [OUT_W-1:0]  matmul [0:N-1][0:N-1]
);
  logic [DATA_W-1:0] w_bt [0:N-1][0:N-1];
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      assign w_bt[j][i] = b[i][j];
      matrix_mult_dot #(.N(N), .DATA_W(DATA_W), .OUT_W(OUT_W)) u_dot (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .i_a(a[i]),
        .i_b(w_bt[j]),
        .o_dot(matmul[i][j])
      );
    end
  end
endmodule

// File: tb/tb_matrix_mult.sv
// tb_matrix_mult: directed self-checking bench for matrix_mult (N=3, 8-bit in, 16-bit out)
module tb_matrix_mult;
  typedef int mat_t [0:2][0:2];
  logic       clk = 0;
  logic       reset = 1;
  logic       enable = 1;
  logic [7:0] a [0:2][0:2];
  logic [7:0] b [0:2][0:2];
  logic [15:0] matmul [0:2][0:2];
  int n_chk = 0;
  int n_err = 0;
  mat_t ma, mb, mi, mr, mf, mz;
  mat_t pa [0:3];
  mat_t pb [0:3];
  mat_t pe [0:3];
  int big;
  matrix_mult dut (.clk(clk), .reset(reset), .enable(enable), .a(a), .b(b), .matmul(matmul));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic chk_mat(input string tag, input mat_t e);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) chk($sformatf("%s[%0d][%0d]", tag, i, j), int'(matmul[i][j]), e[i][j]);
  endtask
  task automatic set_ab(input mat_t x, input mat_t y);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        a[i][j] = 8'(x[i][j]);
        b[i][j] = 8'(y[i][j]);
      end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    ma = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    mb = '{'{9, 8, 7}, '{6, 5, 4}, '{3, 2, 1}};
    mi = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}};
    mr = '{'{30, 24, 18}, '{84, 69, 54}, '{138, 114, 90}};
    mf = '{default: '{default: 255}};
    mz = '{default: '{default: 0}};
`ifdef MATMUL_SAT_EN
    big = 65535;
`else
    big = 64003;
`endif
    set_ab(ma, mb);
    step(2);
    chk_mat("in_reset", mz);
    reset = 0;
    step(1);
    chk_mat("post_rst_1edge", mz);
    step(1);
    chk_mat("basic", mr);
    step(2);
    chk_mat("basic_hold", mr);
    set_ab(ma, mi);
    step(2);
    chk_mat("identity", ma);
    set_ab(mf, mf);
    step(2);
    chk_mat("all255", '{default: '{default: big}});
    set_ab(ma, mb);
    step(1);
    enable = 0;
    set_ab(ma, mi);
    for (int c = 0; c < 5; c++) begin
      step(1);
      chk($sformatf("stall_c%0d", c), int'(matmul[1][1]), big);
    end
    chk_mat("stall_end", '{default: '{default: big}});
    enable = 1;
    step(1);
    chk_mat("resume_old", mr);
    step(1);
    chk_mat("resume_new", ma);
    pa = '{ma, ma, mf, mz};
    pb = '{mb, mi, mf, mb};
    pe = '{mr, ma, '{default: '{default: big}}, mz};
    for (int t = 0; t < 6; t++) begin
      if (t >= 2) chk_mat($sformatf("b2b%0d", t - 2), pe[t-2]);
      if (t < 4) set_ab(pa[t], pb[t]);
      else set_ab(ma, mb);
      step(1);
    end
    chk_mat("b2b_tail", mr);
    set_ab(mf, mf);
    reset = 1;
    step(1);
    chk_mat("mid_reset", mz);
    reset = 0;
    set_ab(ma, mb);
    step(1);
    chk_mat("mid_reset_1edge", mz);
    step(1);
    chk_mat("mid_reset_result", mr);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
